// File: rtl/crc_stream_engine.sv
// crc_stream_engine: folds DATA_W bits per accepted beat into a CRC_W-bit LFSR and
// presents each frame's CRC on a registered valid/ready result port.
// Optional: define CRC_RESIDUE_CHECK_EN to add the RESIDUE parameter and crc_ok output.
module crc_stream_engine #(
    parameter int unsigned      CRC_W      = 16,
    parameter logic [CRC_W-1:0] POLY       = 16'h1021,
    parameter logic [CRC_W-1:0] INIT       = '1,
    parameter logic [CRC_W-1:0] XOR_OUT    = '0,
    parameter int unsigned      DATA_W     = 8,
    parameter bit               REFLECT_IN = 1'b0
`ifdef CRC_RESIDUE_CHECK_EN
    , parameter logic [CRC_W-1:0] RESIDUE  = '0
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  crc_out
`ifdef CRC_RESIDUE_CHECK_EN
    , output logic            crc_ok
`endif
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    logic [CRC_W-1:0]   lfsr;
    logic [CRC_W-1:0]   next_lfsr;
    logic [DATA_W-1:0]  data_rev;
    logic [DATA_W-1:0]  data_sh;
    logic               fb;
    logic               accept;

    for (genvar g = 0; g < DATA_W; g++) begin : g_rev
        assign data_rev[g] = in_data[DATA_W-1-g];
    end

    // Beat is shifted out MSB-first; LSB-first ordering is handled by pre-reversing it.
    always_comb begin
        data_sh   = REFLECT_IN ? data_rev : in_data;
        next_lfsr = lfsr;
        fb        = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            fb        = data_sh[DATA_W-1] ^ next_lfsr[CRC_W-1];
            next_lfsr = {next_lfsr[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            data_sh   = data_sh << 1;
        end
    end

    always_comb begin
        in_ready = !init && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lfsr      <= INIT;
            out_valid <= 1'b0;
            crc_out   <= '0;
`ifdef CRC_RESIDUE_CHECK_EN
            crc_ok    <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            if (init) begin
                state <= IDLE;
                lfsr  <= INIT;
            end else if (accept) begin
                if (in_last) begin
                    // A last beat overrides a same-edge consume so the new result stays valid.
                    lfsr      <= INIT;
                    out_valid <= 1'b1;
                    crc_out   <= next_lfsr ^ XOR_OUT;
`ifdef CRC_RESIDUE_CHECK_EN
                    crc_ok    <= (next_lfsr == RESIDUE);
`endif
                end else begin
                    lfsr <= next_lfsr;
                end

                case (state)
                    IDLE:    state <= in_last ? IDLE : BUSY;
                    BUSY:    state <= in_last ? IDLE : BUSY;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
